// File: rtl/hamwt_pkt_gen.sv
// Packet regenerator: expands a list of set-bit locations into a framed byte stream
// (FRAME pulse, pkt_len data bytes, FIN pulse) for the hamming-weight/location receiver.
module hamwt_pkt_gen (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic [7:0]   pkt_len,
  input  logic [4:0]   ham_wt,
  input  logic [309:0] locn_ones,
  output logic         pkt_starts,
  output logic [7:0]   bin_data,
  output logic         data_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, FRAME, DATA, FIN} state_t;

  state_t         state;
  logic [7:0]     len_q;
  logic [4:0]     wt_q;
  logic [309:0]   locn_q;
  logic [6:0]     cnt;

  logic [6:0]     next_idx;
  logic [7:0]     next_byte;
  logic           last_byte;
  logic           len_ok;

  assign len_ok    = (pkt_len != 8'd0) && (pkt_len <= 8'd128);
  assign last_byte = ({1'b0, cnt} == (len_q - 8'd1));

  // Byte to present in the following cycle: index 0 when leaving FRAME, else cnt+1.
  // An entry whose byte index matches is necessarily below 8*pkt_len, so out-of-range
  // entries drop out naturally; duplicates just OR the same bit again.
  always_comb begin
    next_idx  = (state == FRAME) ? 7'd0 : (cnt + 7'd1);
    next_byte = 8'd0;
    for (int k = 0; k < 31; k++) begin
      if ((5'(k) < wt_q) && (locn_q[10*k+3 +: 7] == next_idx))
        next_byte = next_byte | (8'd1 << locn_q[10*k +: 3]);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      len_q      <= 8'd0;
      wt_q       <= 5'd0;
      locn_q     <= '0;
      cnt        <= 7'd0;
      pkt_starts <= 1'b0;
      bin_data   <= 8'd0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            state      <= FRAME;
            len_q      <= pkt_len;
            wt_q       <= ham_wt;
            locn_q     <= locn_ones;
            cnt        <= 7'd0;
            pkt_starts <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FRAME: begin
          state      <= DATA;
          pkt_starts <= 1'b0;
          data_valid <= 1'b1;
          bin_data   <= next_byte;
        end
        DATA: begin
          if (last_byte) begin
            state      <= FIN;
            data_valid <= 1'b0;
            bin_data   <= 8'd0;
            done       <= 1'b1;
          end else begin
            cnt      <= next_idx;
            bin_data <= next_byte;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          cnt   <= 7'd0;
        end
        default: begin
          state      <= IDLE;
          pkt_starts <= 1'b0;
          data_valid <= 1'b0;
          bin_data   <= 8'd0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamwt_pkt_gen.sv
// Directed bench for hamwt_pkt_gen: stimulus pushes hand-computed bytes into a
// scoreboard queue, a negedge monitor pops and compares them against the DUT stream.
module tb_hamwt_pkt_gen;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic [7:0]   pkt_len;
  logic [4:0]   ham_wt;
  logic [309:0] locn_ones;
  logic         pkt_starts;
  logic [7:0]   bin_data;
  logic         data_valid;
  logic         busy;
  logic         done;

  hamwt_pkt_gen dut (
    .clk(clk), .clear(clear), .start(start), .pkt_len(pkt_len), .ham_wt(ham_wt),
    .locn_ones(locn_ones), .pkt_starts(pkt_starts), .bin_data(bin_data),
    .data_valid(data_valid), .busy(busy), .done(done)
  );

  always #50 clk = ~clk;

  int         n_tests  = 0;
  int         n_fail   = 0;
  int         n_starts = 0;
  int         n_done   = 0;
  int         byte_cnt = 0;
  int         cur_len  = -1;
  logic [7:0] exp_q[$];
  int         exp_len_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: frame, data and end-of-packet checks
  always @(negedge clk) begin
    if (clear) begin
      byte_cnt = 0;
      cur_len  = -1;
    end else begin
      if (pkt_starts) begin
        n_starts++;
        byte_cnt = 0;
        check("start_expected", 32'(exp_len_q.size() != 0), 32'd1);
        if (exp_len_q.size() != 0) cur_len = exp_len_q.pop_front();
        check("frame_quiet", {23'd0, data_valid, bin_data}, 32'd0);
      end
      if (data_valid) begin
        if (exp_q.size() == 0) check("byte_unexpected", 32'd1, 32'd0);
        else check("byte", {24'd0, bin_data}, {24'd0, exp_q.pop_front()});
        byte_cnt++;
      end else begin
        check("data_zero_when_invalid", {24'd0, bin_data}, 32'd0);
      end
      if (pkt_starts || data_valid || done) check("busy_in_pkt", {31'd0, busy}, 32'd1);
      if (done) begin
        n_done++;
        check("done_len", byte_cnt, cur_len);
        cur_len = -1;
      end
    end
  end

  task automatic set_ent(input int k, input int b);
    locn_ones[10*k +: 10] = b[9:0];
  endtask

  // Unused entries point at bit 0 of byte k so masking errors show up as stray bits.
  task automatic fill_junk();
    for (int k = 0; k < 31; k++) locn_ones[10*k +: 10] = 10'(8*k);
  endtask

  task automatic send(input int len, input int wt);
    @(posedge clk); #1;
    pkt_len = 8'(len);
    ham_wt  = 5'(wt);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", 32'(i < 400), 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {27'd0, pkt_starts, data_valid, busy, done, |bin_data}, 32'd0);
  endtask

  initial begin
    int starts_before;
    int done_before;
    int i;
    clear = 1'b1; start = 1'b0; pkt_len = 8'd0; ham_wt = 5'd0;
    locn_ones = '0;
    fill_junk();
    #30;
    check_outputs_zero("reset_outputs");
    #100;
    clear = 1'b0;

    // 1: entries 0..7 fill byte 0
    fill_junk();
    for (int k = 0; k < 8; k++) set_ent(k, k);
    exp_len_q.push_back(2); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send(2, 8);
    wait_idle();

    // 2: bits 3,5,7 of a single byte
    fill_junk();
    set_ent(0, 3); set_ent(1, 5); set_ent(2, 7);
    exp_len_q.push_back(1); exp_q.push_back(8'hA8);
    send(1, 3);
    wait_idle();

    // 3: maximum length, duplicated top bit
    fill_junk();
    set_ent(0, 1023); set_ent(1, 1023);
    exp_len_q.push_back(128);
    for (int j = 0; j < 127; j++) exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    send(128, 2);
    wait_idle();

    // 4: out-of-range entry dropped, then zero weight
    fill_junk();
    set_ent(0, 9); set_ent(1, 40);
    exp_len_q.push_back(2); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    send(2, 2);
    wait_idle();
    exp_len_q.push_back(2); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send(2, 0);
    wait_idle();

    // 5: starts while busy (DATA and FIN) and with illegal lengths are ignored
    fill_junk();
    set_ent(0, 8);
    exp_len_q.push_back(3);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    starts_before = n_starts;
    send(3, 1);
    @(posedge clk); #1;
    start = 1'b1; pkt_len = 8'd1; ham_wt = 5'd31; locn_ones = '1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_in_data", {31'd0, busy}, 32'd1);
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_timeout", 32'(i < 20), 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("fin_start_ignored", {31'd0, busy}, 32'd0);
    check("no_extra_start", n_starts, starts_before + 1);
    check("queue_drained", exp_q.size(), 32'd0);
    send(0, 3);
    @(negedge clk);
    check("len0_busy", {31'd0, busy}, 32'd0);
    send(200, 3);
    @(negedge clk);
    check("len200_busy", {31'd0, busy}, 32'd0);
    check("illegal_no_start", n_starts, starts_before + 1);

    // 6: asynchronous abort during byte 2 of 4, then a fresh packet
    fill_junk();
    set_ent(0, 0); set_ent(1, 8); set_ent(2, 16); set_ent(3, 24);
    exp_len_q.push_back(4);
    for (int j = 0; j < 4; j++) exp_q.push_back(8'h01);
    done_before = n_done;
    send(4, 4);
    repeat (3) @(posedge clk);
    #20;
    check("byte2_valid", {31'd0, data_valid}, 32'd1);
    clear = 1'b1;
    #10;
    check_outputs_zero("clear_async");
    exp_q.delete();
    #40;
    clear = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs_zero("after_abort");
    check("no_done_on_abort", n_done, done_before);
    fill_junk();
    set_ent(0, 3); set_ent(1, 5);
    exp_len_q.push_back(2); exp_q.push_back(8'h28); exp_q.push_back(8'h00);
    send(2, 2);
    wait_idle();
    check("done_after_restart", n_done, done_before + 1);

    check("start_total", n_starts, 32'd8);
    check("done_total", n_done, 32'd7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
